pipe_alu_gen: RTL and testbench

Parametrised 4-stage pipelined ALU with integrated register bank and data memory, built as the successor of the team's fixed 16-bit two-phase pipe. It runs on a single clock and carries a valid bit per stage. Operand bypassing allows back-to-back dependent instructions without stalls. It adds per-instruction write enables, a load-immediate, signed ops, result flags, and a memory read-back port. It sits behind the instruction sequencer as the datapath core.

---
 rtl/pipe_alu_gen.sv | 233 +++++++++++++++++++++++
 tb/tb_pipe_alu_gen.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_alu_gen.sv
// pipe_alu_gen: 4-stage pipelined ALU with register bank and data memory.
//
// Stages (one instruction per clock, no stalls):
//   RD  - operands fetched from regbank or bypassed, control latched
//   EX  - ALU result and error flag latched
//   WB  - regbank write, z_out / z_flags / z_valid update
//   MEM - store of the WB result into data memory
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid                   instruction present this cycle
//   rs1, rs2, rd               source A, source B, destination register
//   func, imm, addr            opcode, LDI immediate, store address
//   rf_we, mem_we              per-instruction regbank / memory write enables
//   z_out, z_valid, z_flags    WB result, qualifier, {err, neg, zero}
//   mem_raddr, mem_rdata       read-back address, registered read data
module pipe_alu_gen #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RA_W   = 4,
  parameter int unsigned MA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [RA_W-1:0]   rs1,
  input  logic [RA_W-1:0]   rs2,
  input  logic [RA_W-1:0]   rd,
  input  logic [3:0]        func,
  input  logic [DATA_W-1:0] imm,
  input  logic [MA_W-1:0]   addr,
  input  logic              rf_we,
  input  logic              mem_we,
  output logic [DATA_W-1:0] z_out,
  output logic              z_valid,
  output logic [2:0]        z_flags,
  input  logic [MA_W-1:0]   mem_raddr,
  output logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned NumRegs  = 2 ** RA_W;
  localparam int unsigned NumWords = 2 ** MA_W;

  typedef enum logic [3:0] {
    OpAdd, OpSub, OpMul, OpPassA, OpPassB, OpAnd, OpOr, OpXor,
    OpNegA, OpNegB, OpSrl, OpShl, OpSra, OpSlt, OpLdi, OpIll
  } op_e;

  logic [DATA_W-1:0] rf_q  [NumRegs];
  logic [DATA_W-1:0] mem_q [NumWords];

  // RD -> EX
  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_a_q, s1_b_q, s1_imm_q;
  logic [RA_W-1:0]   s1_rd_q;
  op_e               s1_func_q;
  logic [MA_W-1:0]   s1_addr_q;
  logic              s1_rf_we_q, s1_mem_we_q;

  // EX -> WB
  logic              s2_valid_q;
  logic [DATA_W-1:0] s2_res_q;
  logic              s2_err_q;
  logic [RA_W-1:0]   s2_rd_q;
  logic [MA_W-1:0]   s2_addr_q;
  logic              s2_rf_we_q, s2_mem_we_q;

  // WB -> MEM
  logic [DATA_W-1:0] z_out_q;
  logic              z_valid_q;
  logic [2:0]        z_flags_q;
  logic              s3_store_q;
  logic [MA_W-1:0]   s3_addr_q;

  logic [DATA_W-1:0] mem_rdata_q;

  logic [DATA_W-1:0] ex_res;
  logic              ex_err;
  logic              ex_fwd, wb_fwd;
  logic [DATA_W-1:0] op_a, op_b;

  // ---------------------------------------------------------------------------
  // EX stage ALU
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_res = '0;
    unique case (s1_func_q)
      OpAdd:   ex_res = s1_a_q + s1_b_q;
      OpSub:   ex_res = s1_a_q - s1_b_q;
      OpMul:   ex_res = s1_a_q * s1_b_q;
      OpPassA: ex_res = s1_a_q;
      OpPassB: ex_res = s1_b_q;
      OpAnd:   ex_res = s1_a_q & s1_b_q;
      OpOr:    ex_res = s1_a_q | s1_b_q;
      OpXor:   ex_res = s1_a_q ^ s1_b_q;
      OpNegA:  ex_res = -s1_a_q;
      OpNegB:  ex_res = -s1_b_q;
      OpSrl:   ex_res = {1'b0, s1_a_q[DATA_W-1:1]};
      OpShl:   ex_res = {s1_a_q[DATA_W-2:0], 1'b0};
      OpSra:   ex_res = {s1_a_q[DATA_W-1], s1_a_q[DATA_W-1:1]};
      OpSlt:   ex_res = {{(DATA_W-1){1'b0}}, $signed(s1_a_q) < $signed(s1_b_q)};
      OpLdi:   ex_res = s1_imm_q;
      OpIll:   ex_res = '0;
    endcase
  end

  assign ex_err = (s1_func_q == OpIll);

  // ---------------------------------------------------------------------------
  // Operand bypass: youngest producer wins. Illegal ops never forward since
  // they never write the regbank either.
  // ---------------------------------------------------------------------------
  assign ex_fwd = s1_valid_q & s1_rf_we_q & ~ex_err;
  assign wb_fwd = s2_valid_q & s2_rf_we_q & ~s2_err_q;

  always_comb begin
    op_a = rf_q[rs1];
    if (ex_fwd && (s1_rd_q == rs1)) begin
      op_a = ex_res;
    end else if (wb_fwd && (s2_rd_q == rs1)) begin
      op_a = s2_res_q;
    end
  end

  always_comb begin
    op_b = rf_q[rs2];
    if (ex_fwd && (s1_rd_q == rs2)) begin
      op_b = ex_res;
    end else if (wb_fwd && (s2_rd_q == rs2)) begin
      op_b = s2_res_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_imm_q    <= '0;
      s1_rd_q     <= '0;
      s1_func_q   <= OpAdd;
      s1_addr_q   <= '0;
      s1_rf_we_q  <= 1'b0;
      s1_mem_we_q <= 1'b0;
    end else begin
      s1_valid_q  <= in_valid;
      s1_a_q      <= op_a;
      s1_b_q      <= op_b;
      s1_imm_q    <= imm;
      s1_rd_q     <= rd;
      s1_func_q   <= op_e'(func);
      s1_addr_q   <= addr;
      s1_rf_we_q  <= rf_we;
      s1_mem_we_q <= mem_we;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_res_q    <= '0;
      s2_err_q    <= 1'b0;
      s2_rd_q     <= '0;
      s2_addr_q   <= '0;
      s2_rf_we_q  <= 1'b0;
      s2_mem_we_q <= 1'b0;
    end else begin
      s2_valid_q  <= s1_valid_q;
      s2_res_q    <= ex_res;
      s2_err_q    <= ex_err;
      s2_rd_q     <= s1_rd_q;
      s2_addr_q   <= s1_addr_q;
      s2_rf_we_q  <= s1_rf_we_q;
      s2_mem_we_q <= s1_mem_we_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z_out_q    <= '0;
      z_valid_q  <= 1'b0;
      z_flags_q  <= '0;
      s3_store_q <= 1'b0;
      s3_addr_q  <= '0;
    end else begin
      z_out_q    <= s2_res_q;
      z_valid_q  <= s2_valid_q;
      // Flags are forced to zero for bubbles so consumers can ignore z_valid.
      z_flags_q  <= s2_valid_q ? {s2_err_q, s2_res_q[DATA_W-1], s2_res_q == '0} : 3'b000;
      s3_store_q <= s2_valid_q & s2_mem_we_q & ~s2_err_q;
      s3_addr_q  <= s2_addr_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Register bank (written at WB)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_fwd) begin
      rf_q[s2_rd_q] <= s2_res_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Data memory: not reset, but stores are suppressed while reset is low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n && s3_store_q) begin
      mem_q[s3_addr_q] <= z_out_q;
    end
  end

  // Read-before-write: a same-edge store is seen one edge later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_rdata_q <= '0;
    end else begin
      mem_rdata_q <= mem_q[mem_raddr];
    end
  end

  assign z_out     = z_out_q;
  assign z_valid   = z_valid_q;
  assign z_flags   = z_flags_q;
  assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_pipe_alu_gen.sv
module tb_pipe_alu_gen;

  localparam int DW = 16;
  localparam int RW = 4;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [RW-1:0] rs1, rs2, rd;
  logic [3:0]    func;
  logic [DW-1:0] imm;
  logic [MW-1:0] addr;
  logic          rf_we, mem_we;
  logic [DW-1:0] z_out;
  logic          z_valid;
  logic [2:0]    z_flags;
  logic [MW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  pipe_alu_gen #(
    .DATA_W(DW),
    .RA_W  (RW),
    .MA_W  (MW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .func     (func),
    .imm      (imm),
    .addr     (addr),
    .rf_we    (rf_we),
    .mem_we   (mem_we),
    .z_out    (z_out),
    .z_valid  (z_valid),
    .z_flags  (z_flags),
    .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic [DW-1:0] res;
    logic [2:0]    flags;
  } exp_t;

  typedef struct packed {
    logic [MW-1:0] a;
    logic [DW-1:0] d;
  } store_t;

  exp_t          exp_q[$];
  store_t        pend_q[$];
  logic [DW-1:0] m_rf [2**RW];
  logic [DW-1:0] m_mem [2**MW];
  bit            m_known [2**MW];
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  // Reference ALU, computed with wide integer arithmetic then reduced mod 2**DW.
  function automatic logic [DW-1:0] ref_alu(input logic [3:0] f, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b, input logic [DW-1:0] im);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint t;
    case (f)
      4'd0:  t = ua + ub;
      4'd1:  t = ua - ub;
      4'd2:  t = ua * ub;
      4'd3:  t = ua;
      4'd4:  t = ub;
      4'd5:  t = ua & ub;
      4'd6:  t = ua | ub;
      4'd7:  t = ua ^ ub;
      4'd8:  t = -ua;
      4'd9:  t = -ub;
      4'd10: t = ua / 2;
      4'd11: t = ua * 2;
      4'd12: t = (sa - (sa & 1)) / 2;
      4'd13: t = (sa < sb) ? 1 : 0;
      4'd14: t = longint'(im);
      default: t = 0;
    endcase
    return t[DW-1:0];
  endfunction

  // Drive one instruction for the next edge; the model updates in program order.
  task automatic issue(input logic [3:0] f, input logic [RW-1:0] d, input logic [RW-1:0] a1,
                       input logic [RW-1:0] a2, input logic [DW-1:0] im, input logic rfw,
                       input logic mw, input logic [MW-1:0] ad);
    logic [DW-1:0] r;
    exp_t          e;
    store_t        s;
    bit            err;
    in_valid = 1'b1;
    func = f; rd = d; rs1 = a1; rs2 = a2; imm = im; rf_we = rfw; mem_we = mw; addr = ad;
    r   = ref_alu(f, m_rf[a1], m_rf[a2], im);
    err = (f == 4'd15);
    e.res   = r;
    e.flags = {err, r[DW-1], r == '0};
    exp_q.push_back(e);
    if (rfw && !err) m_rf[d] = r;
    if (mw && !err) begin
      s.a = ad;
      s.d = r;
      pend_q.push_back(s);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    store_t s;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    while (pend_q.size() > 0) begin
      s = pend_q.pop_front();
      m_mem[s.a]   = s.d;
      m_known[s.a] = 1'b1;
    end
  endtask

  task automatic readback(input logic [MW-1:0] a, input string name);
    mem_raddr = a;
    @(posedge clk);
    #1;
    check(name, 32'(mem_rdata), 32'(m_mem[a]));
    @(negedge clk);
  endtask

  // Monitor: pops one expectation per valid output.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (z_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(z_out), 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          check("z_out", 32'(z_out), 32'(e.res));
          check("z_flags", 32'(z_flags), 32'(e.flags));
        end
      end else begin
        check("z_flags_idle", 32'(z_flags), 32'd0);
      end
    end
  end

  initial begin
    int budget;
    for (int i = 0; i < 2**RW; i++) m_rf[i] = '0;
    for (int i = 0; i < 2**MW; i++) begin
      m_mem[i]   = '0;
      m_known[i] = 1'b0;
    end

    // 1. Reset held with a live LDI on the inputs.
    rst_n = 1'b0; in_valid = 1'b1; func = 4'd14; imm = 16'hAAAA; rf_we = 1'b1;
    mem_we = 1'b1; addr = 8'h40; rs1 = '0; rs2 = '0; rd = 4'd0; mem_raddr = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_z_valid", 32'(z_valid), 32'd0);
    check("rst_z_out", 32'(z_out), 32'd0);
    check("rst_z_flags", 32'(z_flags), 32'd0);
    check("rst_mem_rdata", 32'(mem_rdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    issue(4'd0, 4'd0, 4'd0, 4'd0, '0, 1'b1, 1'b0, '0);        // ADD r0 = r0 + r0
    drain();

    // 2. Back-to-back dependents through EX and WB bypass.
    issue(4'd14, 4'd1, 4'd0, 4'd0, 16'd5, 1'b1, 1'b0, '0);
    issue(4'd14, 4'd2, 4'd0, 4'd0, 16'd3, 1'b1, 1'b0, '0);
    issue(4'd0,  4'd3, 4'd1, 4'd2, '0, 1'b1, 1'b0, '0);
    issue(4'd1,  4'd4, 4'd2, 4'd1, '0, 1'b1, 1'b0, '0);
    drain();

    // 3. Multiply truncation, signed compare, arithmetic shift.
    issue(4'd14, 4'd5,  4'd0, 4'd0, 16'h0100, 1'b1, 1'b0, '0);
    issue(4'd2,  4'd6,  4'd5, 4'd5, '0, 1'b1, 1'b0, '0);
    issue(4'd14, 4'd8,  4'd0, 4'd0, 16'h8000, 1'b1, 1'b0, '0);
    issue(4'd14, 4'd9,  4'd0, 4'd0, 16'h0001, 1'b1, 1'b0, '0);
    issue(4'd13, 4'd10, 4'd8, 4'd9, '0, 1'b1, 1'b0, '0);
    issue(4'd12, 4'd11, 4'd8, 4'd0, '0, 1'b1, 1'b0, '0);
    drain();

    // 4. Store timing on the read-back port.
    issue(4'd14, 4'd12, 4'd0, 4'd0, 16'h0BAD, 1'b1, 1'b1, 8'hFF);
    drain();
    mem_raddr = 8'hFF;
    issue(4'd14, 4'd7, 4'd0, 4'd0, 16'h1234, 1'b1, 1'b1, 8'hFF);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mem_old_on_store_edge", 32'(mem_rdata), 32'h0BAD);
    @(posedge clk);
    #1;
    check("mem_new_after_store", 32'(mem_rdata), 32'h1234);
    @(negedge clk);
    drain();

    // 5. Illegal opcode: err flag, no writes, no forwarding.
    issue(4'd15, 4'd1, 4'd1, 4'd1, 16'hFFFF, 1'b1, 1'b1, 8'hFF);
    issue(4'd0,  4'd13, 4'd1, 4'd1, '0, 1'b1, 1'b0, '0);
    drain();
    readback(8'hFF, "mem_after_illegal");

    // 6. Reset discards in-flight stores.
    for (int i = 0; i < 3; i++) issue(4'd14, 4'd14, 4'd0, 4'd0, 16'h0055, 1'b1, 1'b1, 8'(16 + i));
    drain();
    for (int i = 0; i < 3; i++) issue(4'd14, 4'd15, 4'd0, 4'd0, 16'h0077, 1'b1, 1'b1, 8'(16 + i));
    rst_n = 1'b0;
    exp_q.delete();
    pend_q.delete();
    for (int i = 0; i < 2**RW; i++) m_rf[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    check("z_valid_after_reset", 32'(z_valid), 32'd0);
    drain();
    for (int i = 0; i < 3; i++) readback(8'(16 + i), "mem_kept_over_reset");

    // Random stream with bubbles and occasional stores.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(7) == 0) begin
        in_valid = 1'b0;
        func = 4'($urandom);
        @(negedge clk);
      end else begin
        issue(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom),
              1'($urandom_range(3) != 0), 1'($urandom_range(3) == 0),
              8'(8'h20 + $urandom_range(31)));
      end
    end
    drain();
    for (int a = 8'h20; a < 8'h40; a++) begin
      if (m_known[a]) readback(8'(a), "mem_random");
    end

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
